// File: rtl/fpu_bcd_to_binary.sv
// Packed-BCD (8087 FBLD format) to unsigned binary converter.
// Digit-serial multiply-accumulate, most significant digit first.
module fpu_bcd_to_binary #(
  parameter int NUM_DIGITS = 18,
  parameter int ACC_WIDTH  = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [4*NUM_DIGITS+7:0]   bcd_in,
  output logic [ACC_WIDTH-1:0]      binary_out,
  output logic                      sign_out,
  output logic                      done,
  output logic                      error
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         shift_q, shift_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            dig_q, dig_d;
  logic                  dig_vld_q, dig_vld_d;
  logic                  inv_q, inv_d;
  logic                  sign_lat_q, sign_lat_d;
  logic [ACC_WIDTH-1:0]  bin_q, bin_d;
  logic                  sign_q, sign_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Pad bits between the sign and the digit field carry no meaning.
  logic unused_pad;
  assign unused_pad = ^bcd_in[DW+6:DW];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      dig_q      <= '0;
      dig_vld_q  <= 1'b0;
      inv_q      <= 1'b0;
      sign_lat_q <= 1'b0;
      bin_q      <= '0;
      sign_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      dig_vld_q  <= dig_vld_d;
      inv_q      <= inv_d;
      sign_lat_q <= sign_lat_d;
      bin_q      <= bin_d;
      sign_q     <= sign_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dig_d      = dig_q;
    dig_vld_d  = dig_vld_q;
    inv_d      = inv_q;
    sign_lat_d = sign_lat_q;
    bin_d      = bin_q;
    sign_d     = sign_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        err_d  = 1'b0;
        if (enable) begin
          shift_d    = bcd_in[DW-1:0];
          sign_lat_d = bcd_in[DW+7];
          acc_d      = '0;
          inv_d      = 1'b0;
          cnt_d      = CW'(NUM_DIGITS);
          dig_vld_d  = 1'b0;
          state_d    = CONVERT;
        end
      end

      CONVERT: begin
        // The fetched digit is registered before the adder, so accumulation
        // trails the fetch by one cycle and the shift-register mux stays off
        // the carry path.
        if (dig_vld_q) begin
          acc_d = (acc_q << 3) + (acc_q << 1) + ACC_WIDTH'(dig_q);
          if (dig_q > 4'd9) inv_d = 1'b1;
        end
        if (cnt_q != '0) begin
          dig_d     = shift_q[DW-1 -: 4];
          dig_vld_d = 1'b1;
          shift_d   = shift_q << 4;
          cnt_d     = cnt_q - CW'(1);
        end else begin
          dig_vld_d = 1'b0;
          if (!dig_vld_q) begin
            bin_d   = acc_q;
            sign_d  = sign_lat_q;
            err_d   = inv_q;
            state_d = DONE_ST;
          end
        end
      end

      DONE_ST: begin
        done_d = 1'b1;
        if (!enable) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign binary_out = bin_q;
  assign sign_out   = sign_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_fpu_bcd_to_binary.sv
// Directed bench for fpu_bcd_to_binary with hand-computed expected results.
module tb_fpu_bcd_to_binary;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [79:0] bcd_in;
  logic [63:0] binary_out;
  logic        sign_out;
  logic        done;
  logic        error;

  int n_pass  = 0;
  int n_total = 0;
  int lat;

  fpu_bcd_to_binary dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .bcd_in     (bcd_in),
    .binary_out (binary_out),
    .sign_out   (sign_out),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drives a request, then counts edges after the start edge until done is seen.
  task automatic run_conv(input logic [79:0] b, output int l);
    @(negedge clk);
    bcd_in = b;
    enable = 1'b1;
    @(posedge clk);
    l = 0;
    while (l < 60) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      l++;
    end
  endtask

  task automatic drop_enable();
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    bcd_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_bin", binary_out, 64'd0);
    chk("rst_sign", {63'd0, sign_out}, 64'd0);
    chk("rst_err", {63'd0, error}, 64'd0);
    reset_n = 1'b1;

    // T1
    run_conv(80'h1234, lat);
    chk("t1_lat", 64'(lat), 64'd21);
    chk("t1_bin", binary_out, 64'h4D2);
    chk("t1_sign", {63'd0, sign_out}, 64'd0);
    chk("t1_err", {63'd0, error}, 64'd0);
    drop_enable();
    chk("t1_done_clr", {63'd0, done}, 64'd0);
    chk("t1_bin_hold", binary_out, 64'h4D2);

    // T2
    run_conv({1'b0, 7'h0, 72'h999999999999999999}, lat);
    chk("t2_lat", 64'(lat), 64'd21);
    chk("t2_bin", binary_out, 64'h0DE0B6B3A763FFFF);
    chk("t2_err", {63'd0, error}, 64'd0);
    drop_enable();

    // T3
    run_conv({1'b1, 7'h7F, 72'h5}, lat);
    chk("t3_bin", binary_out, 64'd5);
    chk("t3_sign", {63'd0, sign_out}, 64'd1);
    chk("t3_err", {63'd0, error}, 64'd0);
    drop_enable();
    run_conv({1'b1, 79'h0}, lat);
    chk("t3_nz_bin", binary_out, 64'd0);
    chk("t3_nz_sign", {63'd0, sign_out}, 64'd1);
    drop_enable();

    // T4
    run_conv({1'b0, 7'h0, 72'hA0}, lat);
    chk("t4_bin", binary_out, 64'd100);
    chk("t4_err", {63'd0, error}, 64'd1);
    chk("t4_sign", {63'd0, sign_out}, 64'd0);
    drop_enable();

    // T5: reset after nine digits have been taken
    @(negedge clk);
    bcd_in = {1'b1, 7'h0, 72'h123456789123456789};
    enable = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_done", {63'd0, done}, 64'd0);
    chk("t5_rst_bin", binary_out, 64'd0);
    chk("t5_rst_err", {63'd0, error}, 64'd0);
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_conv({1'b0, 7'h0, 72'h42}, lat);
    chk("t5_lat", 64'(lat), 64'd21);
    chk("t5_bin", binary_out, 64'd42);

    // T6: enable held after done
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_hold_done", {63'd0, done}, 64'd1);
      chk("t6_hold_bin", binary_out, 64'd42);
    end
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bcd_in = {1'b0, 7'h0, 72'h7};
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_done_fall", {63'd0, done}, 64'd0);
    lat = 1;
    while (lat < 60) begin
      @(posedge clk);
      @(negedge clk);
      if (done) break;
      lat++;
    end
    chk("t6_lat", 64'(lat), 64'd21);
    chk("t6_bin", binary_out, 64'd7);
    chk("t6_sign", {63'd0, sign_out}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
